// File: rtl/uart_rx_capture.sv
// uart_rx_capture: fixed-divisor UART receiver with sticky error flags and a
// first-word-fall-through capture FIFO drained by a single-cycle pop strobe.
module uart_rx_capture #(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        rx,
  input  logic                        en,
  input  logic                        rd,
  input  logic                        clr_err,
  output logic                        valid,
  output logic [DATA_BITS-1:0]        rdata,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        break_det
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Outcome of a completed character, applied to FIFO and flags one cycle later
  typedef struct packed {
    logic                 push;
    logic                 frame;
    logic                 brk;
    logic                 par;
    logic [DATA_BITS-1:0] data;
  } evt_t;

  // ---------------- synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs_prev_q, rxs_prev_d;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    rxs_prev_d = rxs;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      rxs_prev_q <= rxs_prev_d;
    end
  end

  // ---------------- receive FSM ----------------
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  evt_t                 evt_q, evt_d;
  logic                 tick, exp_par;

  assign tick    = (cnt_q == '0);
  assign exp_par = (PARITY == 1) ? ~(^shreg_q) : (^shreg_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? cnt_q : cnt_q - CW'(1);
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    evt_d     = '0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rxs_prev_q && !rxs) begin
            state_d = START;
            cnt_d   = HALF_M1;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              cnt_d     = FULL_M1;
              idx_d     = '0;
              par_bad_d = 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            // LSB arrives first, so shifting in at the top leaves it at bit 0
            shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
            cnt_d   = FULL_M1;
            if (idx_q == LAST_IDX) state_d = (PARITY != 0) ? PAR : STOP;
            else                   idx_d   = idx_q + IW'(1);
          end
        end
        PAR: begin
          if (tick) begin
            par_bad_d = (rxs != exp_par);
            cnt_d     = FULL_M1;
            state_d   = STOP;
          end
        end
        STOP: begin
          // Back to IDLE at the mid-stop sample so a following start edge is not missed
          if (tick) begin
            state_d    = IDLE;
            evt_d.push = rxs && !par_bad_q;
            evt_d.frame = !rxs;
            evt_d.brk  = !rxs && (shreg_q == '0);
            evt_d.par  = par_bad_q;
            evt_d.data = shreg_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
      evt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
      evt_q     <= evt_d;
    end
  end

  // ---------------- FWFT FIFO and sticky flags ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        lvl_q, lvl_d;
  logic                 ovf_q, ovf_d, frm_q, frm_d, perr_q, perr_d, brk_q, brk_d;
  logic                 do_pop, do_push, drop;

  always_comb begin
    do_pop   = rd && (lvl_q != '0);
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push
    do_push  = evt_q.push && ((lvl_q != FULL_LVL) || do_pop);
    drop     = evt_q.push && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    lvl_d    = lvl_q + LW'(do_push) - LW'(do_pop);
    ovf_d    = drop        | (ovf_q  & ~clr_err);
    frm_d    = evt_q.frame | (frm_q  & ~clr_err);
    perr_d   = evt_q.par   | (perr_q & ~clr_err);
    brk_d    = evt_q.brk   | (brk_q  & ~clr_err);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      frm_q    <= 1'b0;
      perr_q   <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      ovf_q    <= ovf_d;
      frm_q    <= frm_d;
      perr_q   <= perr_d;
      brk_q    <= brk_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge HCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= evt_q.data;
  end

  assign valid      = (lvl_q != '0);
  assign rdata      = valid ? mem_q[rd_ptr_q] : '0;
  assign level      = lvl_q;
  assign overflow   = ovf_q;
  assign frame_err  = frm_q;
  assign parity_err = perr_q;
  assign break_det  = brk_q;
endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: three instances (defaults, even parity,
// 4-deep FIFO), each on its own serial line, checked against hand-computed values.
module tb_uart_rx_capture;
  localparam int CPB = 16;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [2:0] rx_v = 3'b111;
  logic [2:0] rd_v = 3'b000;
  logic       en = 1'b1;
  logic       clr_err = 1'b0;

  logic       valid0, ovf0, frm0, perr0, brk0;
  logic [7:0] rdata0;
  logic [4:0] level0;
  logic       valid1, ovf1, frm1, perr1, brk1;
  logic [7:0] rdata1;
  logic [4:0] level1;
  logic       valid2, ovf2, frm2, perr2, brk2;
  logic [7:0] rdata2;
  logic [2:0] level2;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  uart_rx_capture u_def (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx_v[0]), .en(en), .rd(rd_v[0]), .clr_err(clr_err),
    .valid(valid0), .rdata(rdata0), .level(level0), .overflow(ovf0),
    .frame_err(frm0), .parity_err(perr0), .break_det(brk0));

  uart_rx_capture #(.PARITY(2)) u_par (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx_v[1]), .en(en), .rd(rd_v[1]), .clr_err(clr_err),
    .valid(valid1), .rdata(rdata1), .level(level1), .overflow(ovf1),
    .frame_err(frm1), .parity_err(perr1), .break_det(brk1));

  uart_rx_capture #(.FIFO_DEPTH(4)) u_f4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx_v[2]), .en(en), .rd(rd_v[2]), .clr_err(clr_err),
    .valid(valid2), .rdata(rdata2), .level(level2), .overflow(ovf2),
    .frame_err(frm2), .parity_err(perr2), .break_det(brk2));

  // Caller must be at a negedge; leaves the line idle high on return.
  task automatic send(input int u, input logic [8:0] d, input int nb,
                      input bit hp, input logic pb, input logic sb);
    rx_v[u] = 1'b0;
    repeat (CPB) @(negedge HCLK);
    for (int i = 0; i < nb; i++) begin
      rx_v[u] = d[i];
      repeat (CPB) @(negedge HCLK);
    end
    if (hp) begin
      rx_v[u] = pb;
      repeat (CPB) @(negedge HCLK);
    end
    rx_v[u] = sb;
    repeat (CPB) @(negedge HCLK);
    rx_v[u] = 1'b1;
  endtask

  // Returns 1 ns after posedge number n.
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic pop(input int u);
    rd_v[u] = 1'b1;
    @(posedge HCLK);
    #1;
    rd_v[u] = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge HCLK);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge HCLK);
    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid0); end
    n_cmp++; if (level0 !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level0); end
    n_cmp++; if (rdata0 !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata0); end
    n_cmp++; if ({ovf0, frm0, perr0, brk0, ovf2, perr1} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {ovf0, frm0, perr0, brk0, ovf2, perr1}); end
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
  endtask

  task automatic test_single();
    int t0;
    @(negedge HCLK);
    t0 = cyc + 1;
    fork send(0, 9'h041, 8, 1'b0, 1'b0, 1'b1); join_none
    wait_edge(t0 + 154);
    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", valid0); end
    wait_edge(t0 + 155);
    n_cmp++; if (valid0 !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", valid0); end
    n_cmp++; if (rdata0 !== 8'h41) begin n_bad++; $display("FAIL single_rdata: got %h want 41", rdata0); end
    n_cmp++; if (level0 !== 5'd1) begin n_bad++; $display("FAIL single_level: got %0d want 1", level0); end
    pop(0);
    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL single_pop_valid: got %b want 0", valid0); end
    n_cmp++; if (level0 !== 5'd0) begin n_bad++; $display("FAIL single_pop_level: got %0d want 0", level0); end
    wait_edge(t0 + 170);
  endtask

  task automatic test_parity();
    @(negedge HCLK);
    send(1, 9'h003, 8, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge HCLK);
    n_cmp++; if (rdata1 !== 8'h03 || valid1 !== 1'b1) begin
      n_bad++; $display("FAIL par_ok_rdata: got %h/%b want 03/1", rdata1, valid1); end
    n_cmp++; if (perr1 !== 1'b0) begin n_bad++; $display("FAIL par_ok_flag: got %b want 0", perr1); end
    send(1, 9'h003, 8, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge HCLK);
    n_cmp++; if (perr1 !== 1'b1) begin n_bad++; $display("FAIL par_bad_flag: got %b want 1", perr1); end
    n_cmp++; if (level1 !== 5'd1) begin n_bad++; $display("FAIL par_bad_level: got %0d want 1", level1); end
    n_cmp++; if (frm1 !== 1'b0) begin n_bad++; $display("FAIL par_bad_frame: got %b want 0", frm1); end
  endtask

  task automatic test_frame_break();
    @(negedge HCLK);
    send(0, 9'h055, 8, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge HCLK);
    n_cmp++; if (frm0 !== 1'b1) begin n_bad++; $display("FAIL frame_flag: got %b want 1", frm0); end
    n_cmp++; if (brk0 !== 1'b0) begin n_bad++; $display("FAIL frame_nobreak: got %b want 0", brk0); end
    n_cmp++; if (level0 !== 5'd0) begin n_bad++; $display("FAIL frame_nopush: got %0d want 0", level0); end
    pulse_clr();
    n_cmp++; if (frm0 !== 1'b0) begin n_bad++; $display("FAIL frame_clr: got %b want 0", frm0); end
    @(negedge HCLK);
    rx_v[0] = 1'b0;
    repeat (12 * CPB) @(negedge HCLK);
    rx_v[0] = 1'b1;
    repeat (4) @(negedge HCLK);
    n_cmp++; if ({brk0, frm0} !== 2'b11) begin n_bad++; $display("FAIL break_flags: got %b want 11", {brk0, frm0}); end
    n_cmp++; if (level0 !== 5'd0) begin n_bad++; $display("FAIL break_nopush: got %0d want 0", level0); end
    pulse_clr();
    n_cmp++; if ({ovf0, frm0, perr0, brk0, perr1} !== 5'b0) begin
      n_bad++; $display("FAIL clr_all: got %b want 00000", {ovf0, frm0, perr0, brk0, perr1}); end
  endtask

  task automatic test_overflow();
    int t0;
    logic [7:0] exp_d;
    for (int k = 1; k <= 5; k++) begin
      @(negedge HCLK);
      send(2, 9'(8'h11 * k), 8, 1'b0, 1'b0, 1'b1);
    end
    repeat (4) @(negedge HCLK);
    n_cmp++; if (level2 !== 3'd4) begin n_bad++; $display("FAIL ovf_level: got %0d want 4", level2); end
    n_cmp++; if (ovf2 !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf2); end
    for (int k = 1; k <= 4; k++) begin
      exp_d = 8'(8'h11 * k);
      n_cmp++; if (rdata2 !== exp_d) begin n_bad++; $display("FAIL ovf_entry%0d: got %h want %h", k, rdata2, exp_d); end
      pop(2);
    end
    n_cmp++; if (valid2 !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", valid2); end
    pulse_clr();
    n_cmp++; if (ovf2 !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b want 0", ovf2); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge HCLK);
      send(2, 9'(8'hA0 + k), 8, 1'b0, 1'b0, 1'b1);
    end
    @(negedge HCLK);
    t0 = cyc + 1;
    fork send(2, 9'h0A5, 8, 1'b0, 1'b0, 1'b1); join_none
    wait_edge(t0 + 154);
    n_cmp++; if (level2 !== 3'd4) begin n_bad++; $display("FAIL pp_full: got %0d want 4", level2); end
    rd_v[2] = 1'b1;
    wait_edge(t0 + 155);
    rd_v[2] = 1'b0;
    n_cmp++; if (level2 !== 3'd4) begin n_bad++; $display("FAIL pp_level: got %0d want 4", level2); end
    n_cmp++; if (ovf2 !== 1'b0) begin n_bad++; $display("FAIL pp_ovf: got %b want 0", ovf2); end
    wait_edge(t0 + 170);
    for (int k = 2; k <= 5; k++) begin
      exp_d = 8'(8'hA0 + k);
      n_cmp++; if (rdata2 !== exp_d) begin n_bad++; $display("FAIL pp_entry%0d: got %h want %h", k, rdata2, exp_d); end
      pop(2);
    end
  endtask

  task automatic test_glitch_b2b_en();
    int t0;
    @(negedge HCLK);
    rx_v[0] = 1'b0;
    repeat (3) @(negedge HCLK);
    rx_v[0] = 1'b1;
    repeat (200) @(negedge HCLK);
    n_cmp++; if ({valid0, frm0, brk0} !== 3'b000) begin
      n_bad++; $display("FAIL glitch: got %b want 000", {valid0, frm0, brk0}); end
    @(negedge HCLK);
    send(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
    send(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge HCLK);
    n_cmp++; if (level0 !== 5'd2) begin n_bad++; $display("FAIL b2b_level: got %0d want 2", level0); end
    n_cmp++; if (rdata0 !== 8'h5A) begin n_bad++; $display("FAIL b2b_first: got %h want 5a", rdata0); end
    pop(0);
    n_cmp++; if (rdata0 !== 8'hC3) begin n_bad++; $display("FAIL b2b_second: got %h want c3", rdata0); end
    pop(0);
    @(negedge HCLK);
    t0 = cyc + 1;
    fork send(0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1); join_none
    wait_edge(t0 + 40);
    en = 1'b0;
    wait_edge(t0 + 200);
    en = 1'b1;
    repeat (4) @(negedge HCLK);
    n_cmp++; if ({valid0, frm0, perr0, brk0} !== 4'b0000) begin
      n_bad++; $display("FAIL en_drop: got %b want 0000", {valid0, frm0, perr0, brk0}); end
  endtask

  task automatic test_reset_mid();
    int t0;
    @(negedge HCLK);
    send(0, 9'h001, 8, 1'b0, 1'b0, 1'b1);
    send(0, 9'h002, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge HCLK);
    n_cmp++; if (level0 !== 5'd2) begin n_bad++; $display("FAIL rst_pre_level: got %0d want 2", level0); end
    @(negedge HCLK);
    t0 = cyc + 1;
    fork send(0, 9'h07E, 8, 1'b0, 1'b0, 1'b1); join_none
    wait_edge(t0 + 60);
    HRESETn = 1'b0;
    #2;
    n_cmp++; if ({valid0, level0, rdata0} !== 14'd0) begin
      n_bad++; $display("FAIL rst_async: got valid %b level %0d rdata %h want 0", valid0, level0, rdata0); end
    wait_edge(t0 + 170);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge HCLK);
    n_cmp++; if (rdata0 !== 8'h3C || level0 !== 5'd1) begin
      n_bad++; $display("FAIL rst_after: got %h/%0d want 3c/1", rdata0, level0); end
    n_cmp++; if ({frm0, brk0, ovf0} !== 3'b000) begin n_bad++; $display("FAIL rst_after_flags: got %b want 000", {frm0, brk0, ovf0}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_frame_break();
    test_overflow();
    test_glitch_b2b_en();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_capture.md
# uart_rx_capture

Parametrised, synthesizable UART receive-and-capture block that generalises the simulation serial terminal used in the SoC benches. It deserialises one UART line at a fixed divisor with configurable data width and parity, and buffers received characters in a first-word-fall-through FIFO. It reports framing, parity, break and overflow conditions through sticky flags. It sits on a UART TX pin (e.g. `io_out[21]`) in either the bench or a debug island and is drained by a simple pop handshake.

## Interface
- `CLK_PER_BIT`, 16: HCLK cycles per bit. Must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per character, 5–9, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 16: number of entries. Power of two, ≥ 2.
- `SYNC_STAGES`, 2: number of rx synchroniser flops, ≥ 2.

Ports:
- `HCLK` in 1: the single clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line, idle high, asynchronous to HCLK.
- `en` in 1: receiver enable.
- `rd` in 1: pop the head of the FIFO.
- `clr_err` in 1: clear the sticky flags.
- `valid` out 1: FIFO is not empty.
- `rdata` out DATA_BITS: FIFO head. Meaningful only while `valid` is high.
- `level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; a character was dropped because the FIFO was full.
- `frame_err` out 1: sticky; the stop bit was sampled low.
- `parity_err` out 1: sticky; parity mismatch.
- `break_det` out 1: sticky; all data bits were 0 and the stop bit was 0.

## Operation
- Reset value of every output is 0. The synchroniser flops reset to 1. The FSM resets to IDLE and the FIFO pointers reset to 0.
- The FSM has five states: IDLE, START, DATA, PAR, STOP. All sampling uses the synchronised rx (`rxs`).
- **IDLE**
  - A falling edge on `rxs` (previous 1, current 0) with `en`=1 moves the FSM to START.
  - The bit counter loads `CLK_PER_BIT/2-1`.
- **START**
  - At counter expiry, sample `rxs`.
  - If 1: glitch. Return to IDLE with no flag set.
  - If 0: go to DATA. The counter loads `CLK_PER_BIT-1` and the bit index is 0.
- **DATA**
  - At each expiry, shift `rxs` into bit[index] (LSB first).
  - After bit `DATA_BITS-1`, go to PAR if `PARITY`≠0, otherwise go to STOP.
- **PAR**
  - Sample at expiry. Check the sample against XOR(data) for even parity, or ~XOR(data) for odd parity.
  - Latch the result, then go to STOP.
- **STOP**
  - Sample at expiry, then return to IDLE in the same cycle. No full stop-bit wait, so a back-to-back start edge half a bit later is caught.
  - Stop = 0 and data = 0 sets `break_det` and `frame_err`.
  - Stop = 0 otherwise sets `frame_err`.
  - A parity mismatch sets `parity_err`.
  - Push to the FIFO only if stop = 1 and parity is OK. Errored characters are discarded.
- **Push when full:** the character is dropped and `overflow` is set. The FIFO contents are unchanged.
- **Push and pop in the same cycle:**
  - When full: the pop frees a slot, the push is accepted, and `overflow` is not set.
  - In all cases: `level` is unchanged.
- **Pop when empty:** ignored.
- **`rdata`** is the head entry, FWFT. It updates the cycle after a pop.
- **`en` deassertion:**
  - The FSM returns to IDLE in the next cycle and the partial character is abandoned with no flags set.
  - FIFO contents and flags are kept.
- **`clr_err`:** clears all four sticky flags. If a set event occurs in the same cycle, the set wins.
- **Reset mid-character:** the partial character and all FIFO contents are lost. All outputs return to 0 asynchronously.

## Timing
- Let t0 be the first HCLK edge at which the raw `rx` is low.
  - The start edge is seen at t0+`SYNC_STAGES`.
  - The start bit is sampled `CLK_PER_BIT/2` cycles after that.
  - The stop bit is sampled at S = t0 + `SYNC_STAGES` + `CLK_PER_BIT/2` + (`DATA_BITS` + P + 1)·`CLK_PER_BIT`, where P = 1 if parity is enabled, else 0.
- `valid`, `level` and the flags update at S+1.
- With defaults and no parity, S = t0 + 154, so `valid` rises at t0+155.
- Pop latency: `rd`=1 with `valid`=1 at edge n gives the new `rdata`/`level` at n+1.
- Tolerated baud mismatch is ±(`CLK_PER_BIT`/2 − 1) cycles of accumulated drift by the stop-bit sample. This is informative only.

## Test plan
- **Single character.** Defaults, 160 ns/bit at a 10 ns HCLK, send 0x41.
  - At t0+155: `valid`=1, `rdata`=0x41, `level`=1.
  - Pop: `valid`=0 next cycle.
- **Parity.** `PARITY`=2, send 0x03 with parity bit 0 → accepted, `rdata`=0x03.
  - Resend 0x03 with parity bit 1 → `parity_err`=1, `level` unchanged.
- **Framing and break.** Send 0x55 with stop = 0 → `frame_err`=1, `break_det`=0, nothing pushed.
  - Then hold `rx` low for 12 bit times → `break_det`=1.
  - `clr_err` → all flags 0.
- **Overflow and same-cycle push/pop.** `FIFO_DEPTH`=4, send 5 characters without popping → `level`=4, `overflow`=1, and entries 1–4 are intact.
  - Clear the flags. Refill to 4, then assert `rd` exactly in cycle S+1 of a 5th character → `level`=4, `overflow`=0.
- **Glitch, back-to-back and enable.**
  - A 3-cycle low pulse on `rx` → no push, no flag.
  - Two characters back-to-back (stop = 1 bit) → both received in order.
  - Drop `en` mid-character → nothing pushed, no flags.
- **Reset mid-character.** Assert `HRESETn`=0 during the DATA state with `level`=2 → all outputs 0 immediately.
  - After release, the next clean character is received correctly.
